tio_sync_gen: RTL and testbench
===============================

// Module: tio_sync_gen
// PURPOSE
//  Sysclk-domain sync sequencer feeding the SURF/LMK timing path. On a TURF sync request it
//  waits sync_offset sysclks, then restarts the internal sync-phase counter, reloads the sysclk
//  timestamp counter to clk_offset, and optionally pulses the external LMK clock sync.
//  Consumes the sync offset, sync enable and clock offset controls from the ID/control register block.
// PARAMETERS
//  CNT_WIDTH     32  width of free-running sysclk timestamp counter
//  SEQ_LEN       8   sync-phase period in sysclks (power of 2, 2..256)
//  EXT_SYNC_LEN  16  ext_sync_o high time in sysclks (1..255)
// PORTS
//  sys_clk_i        in   1          125 MHz system clock; sole clock
//  sys_rst_n_i      in   1          reset, asynchronous, active-low
//  sync_req_i       in   1          sync request strobe from TURF command decode (1-cycle)
//  sync_offset_i    in   8          delay, request -> fire, in sysclks (quasi-static, from ctrl regs)
//  en_ext_sync_i    in   1          issue external LMK sync when firing (quasi-static)
//  clk_offset_i     in   8          value loaded into timestamp counter at fire (quasi-static)
//  missed_clr_i     in   1          clears sync_missed_o
//  seq_rst_o        out  1          1-cycle strobe: sync sequence restarted
//  seq_phase_o      out  $clog2(SEQ_LEN)  current sync phase, 0 on fire cycle
//  sysclk_count_o   out  CNT_WIDTH  timestamp counter
//  ext_sync_o       out  1          external clock sync pulse to LMK
//  busy_o           out  1          sequencer not IDLE
//  sync_missed_o    out  1          sticky: request arrived while busy
// BEHAVIOUR
//  - Reset (async assert, sync deassert external): all outputs 0, state IDLE, counters 0.
//  - States: IDLE -> WAIT -> FIRE -> (EXT if ext latched) -> IDLE. busy_o = (state != IDLE).
//  - IDLE: sync_req_i at edge k latches sync_offset_i, en_ext_sync_i, clk_offset_i; -> WAIT, dcnt=offset.
//  - WAIT: dcnt decrements each edge; at dcnt==0 -> FIRE. Offset 0 passes WAIT in one cycle.
//  - Fire edge = k+1+offset: sysclk_count_o <= zero-extended clk_offset, seq_phase_o <= 0,
//    seq_rst_o high for the following cycle only; ext_sync_o rises at same edge if ext latched.
//  - FIRE -> EXT (ext latched) holds ext_sync_o for exactly EXT_SYNC_LEN cycles, then -> IDLE;
//    FIRE -> IDLE otherwise. Total busy = 1+offset (+EXT_SYNC_LEN-1 in EXT) cycles.
//  - Outside fire edge: sysclk_count_o +1 per cycle, wraps modulo 2^CNT_WIDTH;
//    seq_phase_o +1 per cycle, wraps SEQ_LEN-1 -> 0. Both run in every state.
//  - sync_req_i while busy_o (incl. the cycle returning to IDLE): ignored, sync_missed_o <= 1.
//  - missed_clr_i and a missed request in same cycle: set wins (sync_missed_o stays 1).
//  - Input changes to offsets/enable after acceptance have no effect on in-flight sequence.
//  - Reset mid-sequence: immediate abort; ext_sync_o drops asynchronously, no seq_rst_o emitted.
//  - All outputs registered; no combinational input-to-output path.
// STRUCTURE
//  - tio_sync_pkg: state enum (IDLE, WAIT, FIRE, EXT), default parameter constants.
//  - Single module, no sub-module: one FSM always_ff plus delay, ext-width, phase and
//    timestamp counters.
// TESTING
//  1 offset=0, ext=0, clk_offset=0x10: req at edge k -> seq_rst_o high after k+1, count reads 0x10,
//    0x11 next cycle, ext_sync_o never rises, busy 1 cycle.
//  2 offset=5, ext=1, EXT_SYNC_LEN=16: req at k -> fire edge k+6, ext_sync_o high exactly 16 cycles,
//    busy_o falls after k+21.
//  3 req during WAIT and on last EXT cycle -> both ignored, sync_missed_o=1; missed_clr_i -> 0;
//    clr coincident with new miss -> stays 1.
//  4 change sync_offset_i 5->200 one cycle after accepted req -> fire still at k+6.
//  5 sys_rst_n_i low mid-EXT -> ext_sync_o, busy_o, counters 0 without clock; next req runs normally.
//  6 CNT_WIDTH=8 free-run: 0xFF -> 0x00 wrap; SEQ_LEN=8 phase 7 -> 0; fire mid-period resets phase to 0.

Source files
------------

// File: rtl/tio_sync_pkg.sv
// Shared types and default constants for the sysclk sync sequencer.
package tio_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2,
    ST_EXT  = 2'd3
  } tio_sync_state_e;

  localparam int DEF_CNT_WIDTH    = 32;
  localparam int DEF_SEQ_LEN      = 8;
  localparam int DEF_EXT_SYNC_LEN = 16;

endpackage

// File: rtl/tio_sync_gen.sv
// Sync sequencer: on a TURF request, waits sync_offset sysclks, then restarts the sync phase,
// reloads the timestamp counter and optionally drives the LMK external sync pulse.
module tio_sync_gen
  import tio_sync_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int SEQ_LEN      = DEF_SEQ_LEN,
  parameter int EXT_SYNC_LEN = DEF_EXT_SYNC_LEN
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rst_n_i,
  input  logic                        sync_req_i,
  input  logic [7:0]                  sync_offset_i,
  input  logic                        en_ext_sync_i,
  input  logic [7:0]                  clk_offset_i,
  input  logic                        missed_clr_i,
  output logic                        seq_rst_o,
  output logic [$clog2(SEQ_LEN)-1:0]  seq_phase_o,
  output logic [CNT_WIDTH-1:0]        sysclk_count_o,
  output logic                        ext_sync_o,
  output logic                        busy_o,
  output logic                        sync_missed_o,
  output logic [1:0]                  state_o
);

  localparam int PW = $clog2(SEQ_LEN);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SEQ_LEN - 1);
  localparam logic [7:0]    EXT_LOAD   = 8'(EXT_SYNC_LEN - 1);
  localparam bit            EXT_MULTI  = (EXT_SYNC_LEN > 1);

  // Valid/ready: sync_req_i is a one-cycle strobe with an implicit ready of (state == IDLE);
  // a strobe seen while not ready is dropped and recorded in sync_missed_o.

  tio_sync_state_e state_q, state_d;
  logic [7:0]      dcnt_q;
  logic [7:0]      ecnt_q;
  logic            ext_en_q;
  logic [7:0]      clk_off_q;

  logic accept;
  logic fire;
  logic busy_d;

  assign state_o = state_q;

  // State register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic. FIRE is the cycle whose closing edge performs the reload, so
  // busy spans 1+offset cycles; offset 0 goes straight to FIRE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sync_req_i) state_d = (sync_offset_i == 8'd0) ? ST_FIRE : ST_WAIT;
      ST_WAIT: if (dcnt_q == 8'd0) state_d = ST_FIRE;
      ST_FIRE: state_d = (ext_en_q && EXT_MULTI) ? ST_EXT : ST_IDLE;
      ST_EXT:  if (ecnt_q <= 8'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    accept = (state_q == ST_IDLE) && sync_req_i;
    fire   = (state_q == ST_FIRE);
    busy_d = (state_d != ST_IDLE);
  end

  // Sequence control: latched parameters, delay and pulse-width counters
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      dcnt_q        <= '0;
      ecnt_q        <= '0;
      ext_en_q      <= 1'b0;
      clk_off_q     <= '0;
      seq_rst_o     <= 1'b0;
      ext_sync_o    <= 1'b0;
      busy_o        <= 1'b0;
      sync_missed_o <= 1'b0;
    end else begin
      seq_rst_o <= fire;
      busy_o    <= busy_d;

      if (accept) begin
        dcnt_q    <= sync_offset_i - 8'd1;
        ext_en_q  <= en_ext_sync_i;
        clk_off_q <= clk_offset_i;
      end else if (state_q == ST_WAIT) begin
        dcnt_q <= dcnt_q - 8'd1;
      end

      // The pulse runs on its own counter so it can outlive the EXT state by one cycle.
      if (fire && ext_en_q) begin
        ext_sync_o <= 1'b1;
        ecnt_q     <= EXT_LOAD;
      end else if (ext_sync_o) begin
        if (ecnt_q == 8'd0) ext_sync_o <= 1'b0;
        else                ecnt_q     <= ecnt_q - 8'd1;
      end

      // A miss has priority over a clear
      if (sync_req_i && busy_o) sync_missed_o <= 1'b1;
      else if (missed_clr_i)    sync_missed_o <= 1'b0;
    end
  end

  // Free-running phase and timestamp counters, reloaded on the fire edge
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      seq_phase_o    <= '0;
      sysclk_count_o <= '0;
    end else if (fire) begin
      seq_phase_o    <= '0;
      sysclk_count_o <= CNT_WIDTH'(clk_off_q);
    end else begin
      seq_phase_o    <= (seq_phase_o == PHASE_LAST) ? '0 : seq_phase_o + 1'b1;
      sysclk_count_o <= sysclk_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_tio_sync_gen.sv
// Directed bench for tio_sync_gen: timing of fire, ext pulse, missed-request flag, reset abort and wraps.
module tb_tio_sync_gen;

  localparam int CW  = 8;
  localparam int SL  = 8;
  localparam int EXL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync_req;
  logic [7:0]    sync_offset;
  logic          en_ext_sync;
  logic [7:0]    clk_offset;
  logic          missed_clr;
  logic          seq_rst;
  logic [2:0]    seq_phase;
  logic [CW-1:0] sysclk_count;
  logic          ext_sync;
  logic          busy;
  logic          sync_missed;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  tio_sync_gen #(.CNT_WIDTH(CW), .SEQ_LEN(SL), .EXT_SYNC_LEN(EXL)) dut (
    .sys_clk_i      (clk),
    .sys_rst_n_i    (rst_n),
    .sync_req_i     (sync_req),
    .sync_offset_i  (sync_offset),
    .en_ext_sync_i  (en_ext_sync),
    .clk_offset_i   (clk_offset),
    .missed_clr_i   (missed_clr),
    .seq_rst_o      (seq_rst),
    .seq_phase_o    (seq_phase),
    .sysclk_count_o (sysclk_count),
    .ext_sync_o     (ext_sync),
    .busy_o         (busy),
    .sync_missed_o  (sync_missed),
    .state_o        (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  // Driver: presents a one-cycle request; returns 1 ns after the accepting edge k
  task automatic send_req(input logic [7:0] off, input logic ext, input logic [7:0] coff);
    sync_offset = off;
    en_ext_sync = ext;
    clk_offset  = coff;
    sync_req    = 1'b1;
    tick();
    sync_req    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync_req = 1'b0; sync_offset = '0; en_ext_sync = 1'b0;
    clk_offset = '0; missed_clr = 1'b0;
    #12;
    checks++;
    if ({seq_rst, seq_phase, sysclk_count, ext_sync, busy, sync_missed, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rst=%b ph=%0d cnt=%h ext=%b busy=%b miss=%b st=%0d, want all 0",
               seq_rst, seq_phase, sysclk_count, ext_sync, busy, sync_missed, state);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_offset0();
    do_reset();
    tick(); tick();
    send_req(8'd0, 1'b0, 8'h10);
    checks++;
    if (busy !== 1'b1 || seq_rst !== 1'b0) begin
      errors++; $display("FAIL o0_after_k: busy=%b rst=%b want 1 0", busy, seq_rst);
    end
    tick();
    checks++;
    if (seq_rst !== 1'b1 || sysclk_count !== 8'h10 || seq_phase !== 3'd0 || busy !== 1'b0 || ext_sync !== 1'b0) begin
      errors++;
      $display("FAIL o0_fire: rst=%b cnt=%h ph=%0d busy=%b ext=%b want 1 10 0 0 0",
               seq_rst, sysclk_count, seq_phase, busy, ext_sync);
    end
    tick();
    checks++;
    if (seq_rst !== 1'b0 || sysclk_count !== 8'h11 || seq_phase !== 3'd1 || ext_sync !== 1'b0) begin
      errors++;
      $display("FAIL o0_next: rst=%b cnt=%h ph=%0d ext=%b want 0 11 1 0", seq_rst, sysclk_count, seq_phase, ext_sync);
    end
  endtask

  task automatic test_ext_pulse();
    logic e_busy, e_ext, e_rst;
    do_reset();
    send_req(8'd5, 1'b1, 8'h33);
    for (int j = 1; j <= 24; j++) begin
      tick();
      e_busy = (j <= 20);
      e_ext  = (j >= 6) && (j <= 21);
      e_rst  = (j == 6);
      checks++;
      if (busy !== e_busy || ext_sync !== e_ext || seq_rst !== e_rst) begin
        errors++;
        $display("FAIL ext_seq k+%0d: busy=%b ext=%b rst=%b want %b %b %b", j, busy, ext_sync, seq_rst, e_busy, e_ext, e_rst);
      end
      if (j == 6) begin
        checks++;
        if (sysclk_count !== 8'h33 || seq_phase !== 3'd0) begin
          errors++; $display("FAIL ext_fire_cnt: cnt=%h ph=%0d want 33 0", sysclk_count, seq_phase);
        end
      end
    end
  endtask

  task automatic test_missed();
    do_reset();
    send_req(8'd3, 1'b1, 8'h00);
    tick();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
    checks++;
    if (sync_missed !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL miss_wait: miss=%b busy=%b want 1 1", sync_missed, busy);
    end
    missed_clr = 1'b1;
    tick();
    missed_clr = 1'b0;
    checks++;
    if (sync_missed !== 1'b0) begin
      errors++; $display("FAIL miss_clr: miss=%b want 0", sync_missed);
    end
    repeat (15) tick();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
    checks++;
    if (sync_missed !== 1'b1 || busy !== 1'b0 || ext_sync !== 1'b1) begin
      errors++; $display("FAIL miss_last_ext: miss=%b busy=%b ext=%b want 1 0 1", sync_missed, busy, ext_sync);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || ext_sync !== 1'b0) begin
      errors++; $display("FAIL miss_not_accepted: busy=%b ext=%b want 0 0", busy, ext_sync);
    end
    missed_clr = 1'b1;
    tick();
    missed_clr = 1'b0;
    checks++;
    if (sync_missed !== 1'b0) begin
      errors++; $display("FAIL miss_clr2: miss=%b want 0", sync_missed);
    end
    send_req(8'd0, 1'b0, 8'h00);
    sync_req = 1'b1;
    missed_clr = 1'b1;
    tick();
    sync_req = 1'b0;
    missed_clr = 1'b0;
    checks++;
    if (sync_missed !== 1'b1) begin
      errors++; $display("FAIL miss_set_wins: miss=%b want 1", sync_missed);
    end
  endtask

  task automatic test_input_change();
    do_reset();
    send_req(8'd5, 1'b0, 8'h44);
    sync_offset = 8'd200;
    en_ext_sync = 1'b1;
    clk_offset  = 8'h99;
    repeat (5) tick();
    checks++;
    if (seq_rst !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL chg_pre_fire: rst=%b busy=%b want 0 1", seq_rst, busy);
    end
    tick();
    checks++;
    if (seq_rst !== 1'b1 || sysclk_count !== 8'h44 || busy !== 1'b0 || ext_sync !== 1'b0) begin
      errors++;
      $display("FAIL chg_fire: rst=%b cnt=%h busy=%b ext=%b want 1 44 0 0", seq_rst, sysclk_count, busy, ext_sync);
    end
  endtask

  task automatic test_reset_mid_ext();
    do_reset();
    send_req(8'd2, 1'b1, 8'h55);
    repeat (6) tick();
    checks++;
    if (ext_sync !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: ext=%b busy=%b want 1 1", ext_sync, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ext_sync, busy, seq_rst, sysclk_count, seq_phase, state} !== '0) begin
      errors++;
      $display("FAIL rst_async: ext=%b busy=%b rst=%b cnt=%h ph=%0d st=%0d want all 0",
               ext_sync, busy, seq_rst, sysclk_count, seq_phase, state);
    end
    #1;
    rst_n = 1'b1;
    tick();
    send_req(8'd1, 1'b0, 8'h20);
    tick();
    checks++;
    if (busy !== 1'b1 || seq_rst !== 1'b0) begin
      errors++; $display("FAIL rst_rerun_wait: busy=%b rst=%b want 1 0", busy, seq_rst);
    end
    tick();
    checks++;
    if (seq_rst !== 1'b1 || sysclk_count !== 8'h20 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_rerun_fire: rst=%b cnt=%h busy=%b want 1 20 0", seq_rst, sysclk_count, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 1; n <= 259; n++) begin
      tick();
      if (n == 7 || n == 8 || n == 255 || n == 256) begin
        checks++;
        if (sysclk_count !== 8'(n) || seq_phase !== 3'(n % 8)) begin
          errors++;
          $display("FAIL wrap n=%0d: cnt=%h ph=%0d want %h %0d", n, sysclk_count, seq_phase, 8'(n), n % 8);
        end
      end
    end
    send_req(8'd0, 1'b0, 8'hA0);
    checks++;
    if (seq_phase !== 3'd4 || sysclk_count !== 8'h04) begin
      errors++; $display("FAIL wrap_pre_fire: ph=%0d cnt=%h want 4 04", seq_phase, sysclk_count);
    end
    tick();
    checks++;
    if (seq_phase !== 3'd0 || sysclk_count !== 8'hA0) begin
      errors++; $display("FAIL wrap_fire: ph=%0d cnt=%h want 0 a0", seq_phase, sysclk_count);
    end
    tick();
    checks++;
    if (seq_phase !== 3'd1 || sysclk_count !== 8'hA1) begin
      errors++; $display("FAIL wrap_post: ph=%0d cnt=%h want 1 a1", seq_phase, sysclk_count);
    end
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_ext_pulse();
    test_missed();
    test_input_change();
    test_reset_mid_ext();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
